// File: rtl/alu_arbiter_if.sv
// Bundles the two requester handshakes, the shared result bus and the ALU drive/return signals.
// Latency: none, wiring only.
// Backpressure: carried by req_ready / rsp_ready inside the bundle.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req_op0;
  logic [3:0]       req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic [4:0]       req_shamt0;
  logic [4:0]       req_shamt1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_zero;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_shamt;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             busy;

  // Requesters plus the ALU itself: drive requests, accept results, return ALU outputs.
  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
           req_shamt0, req_shamt1, rsp_ready, alu_out, alu_zero,
    input  req_ready, rsp_valid, rsp_out, rsp_zero, alu_op, alu_a, alu_b,
           alu_shamt, busy
  );

  // The arbiter: accepts requests, drives the ALU, returns results.
  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
           req_shamt0, req_shamt1, rsp_ready, alu_out, alu_zero,
    output req_ready, rsp_valid, rsp_out, rsp_zero, alu_op, alu_a, alu_b,
           alu_shamt, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with round-robin fairness.
// Latency: accept at edge N, result captured at N+1, rsp_valid from cycle N+1; accepts >= 3 cycles apart.
// Backpressure: the result is held until the granted rsp_ready; no request is accepted meanwhile.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant;
  logic             last_grant;
  logic             winner;
  logic             accept;
  logic [1:0]       ready_c;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       shamt_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;

  // Pick the winner: a lone requester wins, on contention the one not granted last time wins.
  always_comb begin
    winner = 1'b0;
    case (bus.req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and request acceptance; ready depends only on state and req_valid.
  always_comb begin
    state_nxt = state;
    ready_c   = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          ready_c[winner] = 1'b1;
          accept          = 1'b1;
          state_nxt       = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready[grant]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch on accept, result capture after the single EXEC cycle; ALU inputs are not cleared after use.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      shamt_q    <= '0;
      out_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      if (accept) begin
        grant      <= winner;
        last_grant <= winner;
        op_q       <= winner ? bus.req_op1    : bus.req_op0;
        a_q        <= winner ? bus.req_a1     : bus.req_a0;
        b_q        <= winner ? bus.req_b1     : bus.req_b0;
        shamt_q    <= winner ? bus.req_shamt1 : bus.req_shamt0;
      end
      if (state == EXEC) begin
        out_q  <= bus.alu_out;
        zero_q <= bus.alu_zero;
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_out   = out_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_shamt = shamt_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a transaction-level reference model.
// Latency: checks accept at N, EXEC at N+1, result held from N+1 until the response handshake.
// Backpressure: random rsp_ready stalls, non-granted rsp_ready noise and contending requesters.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic mdl_last;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: serves as the attached ALU and as the reference for expected results.
  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] sh);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return a << sh;
      4'd9:    return a >> sh;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_out  = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt);
  assign bus.alu_zero = (bus.alu_out != '0);

  // Round-robin rule: lone requester wins, contention goes to the one not granted last.
  function automatic int pick(input logic [1:0] v);
    if (v == 2'b11) return mdl_last ? 0 : 1;
    return v[1] ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    adv();
    adv();
    rst      = 1'b0;
    mdl_last = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh);
    if (i == 0) begin
      bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; bus.req_shamt0 = sh;
    end else begin
      bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; bus.req_shamt1 = sh;
    end
  endtask

  task automatic rand_req(input int i);
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_req(i, 4'($urandom_range(0, 15)), a, b, 5'($urandom_range(0, 31)));
  endtask

  // One full transaction from IDLE with req_valid already driven; returns just after the response handshake.
  task automatic serve(input int hold, input logic [1:0] vld_after);
    int           w;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic [4:0]   sh;
    logic [1:0]   onehot;
    w = pick(bus.req_valid);
    if (w == 1) begin
      op = bus.req_op1; a = bus.req_a1; b = bus.req_b1; sh = bus.req_shamt1;
    end else begin
      op = bus.req_op0; a = bus.req_a0; b = bus.req_b0; sh = bus.req_shamt0;
    end
    e      = alu_ref(op, a, b, sh);
    onehot = (w == 1) ? 2'b10 : 2'b01;
    settle();
    chk("accept_ready", bus.req_ready, onehot);
    chk("idle_busy", bus.busy, 1'b0);
    adv();
    mdl_last          = w[0];
    bus.req_valid     = vld_after;
    bus.rsp_ready[w]  = (hold == 0);
    bus.rsp_ready[1-w] = 1'($urandom_range(0, 1));
    settle();
    chk("exec_busy", bus.busy, 1'b1);
    chk("exec_rsp_valid", bus.rsp_valid, 2'b00);
    chk("exec_req_ready", bus.req_ready, 2'b00);
    chk("exec_alu_op", bus.alu_op, op);
    chk("exec_alu_a", bus.alu_a, a);
    chk("exec_alu_b", bus.alu_b, b);
    chk("exec_alu_shamt", bus.alu_shamt, sh);
    adv();
    for (int k = 0; k <= hold; k++) begin
      if (k == hold) bus.rsp_ready[w] = 1'b1;
      settle();
      chk("resp_valid", bus.rsp_valid, onehot);
      chk("resp_out", bus.rsp_out, e);
      chk("resp_zero", bus.rsp_zero, (e != '0));
      chk("resp_req_ready", bus.req_ready, 2'b00);
      chk("resp_busy", bus.busy, 1'b1);
      adv();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    set_req(0, 4'd0, '0, '0, 5'd0);
    set_req(1, 4'd0, '0, '0, 5'd0);
    mdl_last = 1'b1;

    // Reset state
    do_reset();
    settle();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_rsp_out", bus.rsp_out, 32'd0);
    chk("rst_rsp_zero", bus.rsp_zero, 1'b0);
    chk("rst_alu_op", bus.alu_op, 4'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_shamt", bus.alu_shamt, 5'd0);
    adv();

    // Single add
    set_req(0, 4'd1, 32'd5, 32'd7, 5'd0);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b11;
    #1 chk("add_ready", bus.req_ready, 2'b01);
    serve(0, 2'b00);
    chk("add_out", bus.rsp_out, 32'd12);
    chk("add_zero", bus.rsp_zero, 1'b1);
    settle();
    chk("add_done_busy", bus.busy, 1'b0);
    chk("add_done_rsp_valid", bus.rsp_valid, 2'b00);
    adv();

    // Contention from reset: 0, 1, then 0 again
    do_reset();
    set_req(0, 4'd2, 32'd9, 32'd4, 5'd0);
    set_req(1, 4'd3, 32'd12, 32'd10, 5'd0);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    #1 chk("cont_ready_first", bus.req_ready, 2'b01);
    serve(0, 2'b11);
    chk("cont_out_first", bus.rsp_out, 32'd5);
    #1 chk("cont_ready_second", bus.req_ready, 2'b10);
    serve(0, 2'b11);
    chk("cont_out_second", bus.rsp_out, 32'd8);
    #1 chk("cont_ready_third", bus.req_ready, 2'b01);
    serve(0, 2'b00);
    chk("cont_out_third", bus.rsp_out, 32'd5);

    // Backpressure with requester 0 waiting
    do_reset();
    set_req(1, 4'd8, 32'd1, 32'd0, 5'd4);
    set_req(0, 4'd1, 32'd2, 32'd3, 5'd0);
    bus.req_valid = 2'b10;
    serve(5, 2'b11);
    chk("bp_out", bus.rsp_out, 32'd16);
    #1 chk("bp_next_ready", bus.req_ready, 2'b01);
    serve(0, 2'b00);
    chk("bp_next_out", bus.rsp_out, 32'd5);

    // Zero flag and slt
    set_req(0, 4'd7, 32'hFFFF_FFFF, 32'd0, 5'd0);
    bus.req_valid = 2'b01;
    serve(0, 2'b00);
    chk("slt_out", bus.rsp_out, 32'd1);
    chk("slt_zero", bus.rsp_zero, 1'b1);
    set_req(0, 4'd10, 32'd3, 32'd4, 5'd0);
    bus.req_valid = 2'b01;
    serve(0, 2'b00);
    chk("undef_out", bus.rsp_out, 32'd0);
    chk("undef_zero", bus.rsp_zero, 1'b0);

    // Reset during EXEC
    set_req(0, 4'd1, 32'd1, 32'd2, 5'd3);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    settle();
    adv();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    adv();
    rst = 1'b0;
    mdl_last = 1'b1;
    settle();
    chk("rstx_busy", bus.busy, 1'b0);
    chk("rstx_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rstx_req_ready", bus.req_ready, 2'b00);
    chk("rstx_alu_op", bus.alu_op, 4'd0);
    chk("rstx_alu_a", bus.alu_a, 32'd0);
    chk("rstx_rsp_out", bus.rsp_out, 32'd0);
    adv();

    // Reset during RESP
    set_req(0, 4'd1, 32'd4, 32'd5, 5'd0);
    bus.req_valid = 2'b01;
    settle();
    adv();
    bus.req_valid = 2'b00;
    adv();
    settle();
    chk("rstr_pre_valid", bus.rsp_valid, 2'b01);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    mdl_last = 1'b1;
    settle();
    chk("rstr_busy", bus.busy, 1'b0);
    chk("rstr_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rstr_rsp_out", bus.rsp_out, 32'd0);
    chk("rstr_rsp_zero", bus.rsp_zero, 1'b0);
    chk("rstr_alu_op", bus.alu_op, 4'd0);
    adv();
    set_req(0, 4'd5, 32'hF0, 32'h0F, 5'd0);
    set_req(1, 4'd1, 32'd1, 32'd1, 5'd0);
    bus.req_valid = 2'b11;
    #1 chk("rstr_cont_ready", bus.req_ready, 2'b01);
    serve(0, 2'b00);
    chk("rstr_cont_out", bus.rsp_out, 32'hFF);

    // Withdrawn request from requester 1 while in RESP
    set_req(0, 4'd1, 32'd1, 32'd1, 5'd0);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    settle();
    adv();
    mdl_last = 1'b0;
    bus.req_valid = 2'b00;
    adv();
    bus.req_valid = 2'b10;
    settle();
    chk("wd_ready", bus.req_ready, 2'b00);
    chk("wd_rsp_valid", bus.rsp_valid, 2'b01);
    adv();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    settle();
    chk("wd_rsp_valid_hs", bus.rsp_valid, 2'b01);
    adv();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("wd_idle_busy", bus.busy, 1'b0);
      chk("wd_idle_rsp_valid", bus.rsp_valid, 2'b00);
      chk("wd_idle_ready", bus.req_ready, 2'b00);
      adv();
    end

    // Randomized traffic against the transaction model
    for (int t = 0; t < 150; t++) begin
      logic [1:0] nv;
      nv = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] || (mdl_last == i[0])) rand_req(i);
      end
      bus.req_valid = nv;
      if (nv == 2'b00) begin
        settle();
        chk("rnd_idle_ready", bus.req_ready, 2'b00);
        chk("rnd_idle_busy", bus.busy, 1'b0);
        adv();
      end else begin
        serve($urandom_range(0, 3), 2'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, e.g. the main execute path and a branch or address-compare unit. Each requester uses a valid/ready handshake. The block grants one request at a time with round-robin fairness and latches the operands. It drives the ALU for one cycle, captures the result, and holds it for the granted requester until that requester accepts it.

## Interface
- WIDTH, 32, operand and result width (matches ALU a/b/out)
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; at most one bit high
- req_op0, req_op1  in  4  ALU opcode from requester 0 / 1
- req_a0, req_a1  in  WIDTH  operand a from requester 0 / 1
- req_b0, req_b1  in  WIDTH  operand b from requester 0 / 1
- req_shamt0, req_shamt1  in  5  shift amount from requester 0 / 1
- rsp_valid  out  2  per-requester result valid; at most one bit high
- rsp_ready  in  2  per-requester result accept
- rsp_out  out  WIDTH  captured ALU result, shared by both requesters
- rsp_zero  out  1  captured ALU Zero flag, passed through unaltered
- alu_op  out  4  to ALU ALUop
- alu_a, alu_b  out  WIDTH  to ALU a / b
- alu_shamt  out  5  to ALU shamt
- alu_out  in  WIDTH  from ALU out
- alu_zero  in  1  from ALU Zero; the ALU drives 1 when out is nonzero, and this block does not reinterpret it
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - state = IDLE
  - req_ready = 0, rsp_valid = 0
  - rsp_out = 0, rsp_zero = 0
  - alu_op = 0, alu_a = 0, alu_b = 0, alu_shamt = 0
  - busy = 0
  - grant register = 0, last-grant pointer = 1, so requester 0 wins the first contention
- IDLE:
  - Arbitration is combinational. If only one req_valid bit is set, that requester wins. If both are set, the requester not equal to the last-grant pointer wins.
  - req_ready is high for the winner only, in the same cycle.
  - A handshake completes when req_valid[i] and req_ready[i] are both high.
  - On a handshake: latch op, a, b and shamt into the alu_* registers; record the winner in the grant register; update the last-grant pointer to the winner; go to EXEC.
  - With no valid request, req_ready = 0 and the state stays IDLE.
- EXEC:
  - alu_* registers hold the latched values, so the ALU sees stable inputs for the whole cycle.
  - At the end of the cycle, capture alu_out into rsp_out and alu_zero into rsp_zero, then go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid[grant] = 1. rsp_out and rsp_zero are held stable.
  - When rsp_ready[grant] = 1, go to IDLE; rsp_valid drops the next cycle.
  - rsp_ready on the non-granted bit is ignored.
  - req_ready = 0.
- alu_* registers keep their last values outside EXEC. They are not cleared after use, which saves toggling.
- Opcodes are not checked. Opcode 0 and undefined codes are forwarded as-is, and the ALU returns 0 for them.
- Requesters must hold req_valid and their operand bits stable until req_ready is seen. Dropping req_valid before a grant is legal and loses nothing.
- Reset at any time: the in-flight request and any held result are discarded, and every output returns to its reset value on the next edge. A requester that had been accepted gets no response.

## Timing
- Accept at edge N (IDLE → EXEC). Result captured at edge N+1. rsp_valid is high from cycle N+1 (after edge N+1) onward.
- Minimum spacing between two accepts is 3 cycles when rsp_ready is already high:
  - accept at N
  - rsp_valid during cycle N+1, handshake at edge N+2
  - back in IDLE during cycle N+2, next accept at edge N+3
- No combinational path exists from req_* to alu_* or from alu_out to rsp_out. Both are registered.
- req_ready depends combinationally on req_valid and state only, not on rsp_ready.
- Backpressure: rsp_valid holds for any number of cycles until rsp_ready. No request is accepted meanwhile.
- Fairness: under continuous contention, grants alternate 0, 1, 0, 1, …

## Test plan
- Single add:
  - Stimulus: requester 0, op = 1, a = 5, b = 7, rsp_ready held high.
  - Response: req_ready[0] at cycle 0; rsp_valid = 2'b01 with rsp_out = 12 and rsp_zero = 1 one cycle after EXEC; busy high for 2 cycles.
- Contention:
  - Stimulus: both valid from reset; requester 0 asks op = 2, 9, 4; requester 1 asks op = 3, 12, 10.
  - Response: requester 0 served first (rsp_out = 5), then requester 1 (rsp_out = 8); the next contention goes to 0 again.
- Backpressure:
  - Stimulus: requester 1, op = 8, a = 1, shamt = 4; rsp_ready[1] held low for 5 cycles, with req_valid[0] high throughout.
  - Response: rsp_valid = 2'b10 and rsp_out = 16 stable for all 5 cycles; req_ready stays 0; requester 0 is accepted 1 cycle after the rsp handshake.
- Zero flag and slt:
  - Stimulus: op = 7, a = 32'hFFFF_FFFF, b = 0.
  - Response: rsp_out = 1, rsp_zero = 1. Then op = 10, a = 3, b = 4 gives rsp_out = 0, rsp_zero = 0.
- Reset mid-operation:
  - Stimulus: assert rst during EXEC, then during RESP.
  - Response: next cycle all outputs at reset values, busy = 0, no rsp_valid. The first post-reset contention grants requester 0.
- Withdrawn request:
  - Stimulus: requester 1 valid for 1 cycle while the block is in RESP, then dropped.
  - Response: no accept and no response for requester 1; the state returns to IDLE and stays there.
